// File: rtl/pw_msg_receiver.sv
// Pulse-width serial message receiver: a long high pulse decodes as 1, a short one as 0.
// Completed messages are held for a consumer with valid/ack handshake and sticky overrun.
module pw_msg_receiver #(
   parameter int unsigned MSG_WIDTH     = 24,
   parameter int unsigned CNT_WIDTH     = 6,
   parameter int unsigned ONE_THRESHOLD = 26,
   parameter int unsigned GAP_TIMEOUT   = 48,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           neo_in,
   output logic [MSG_WIDTH-1:0]           msg_data,
   output logic                           msg_valid,
   input  logic                           msg_ack,
   output logic                           overrun,
   output logic                           frame_error,
   output logic                           busy,
   output logic [$clog2(MSG_WIDTH+1)-1:0] bit_count
);

   localparam int unsigned BCW = $clog2(MSG_WIDTH + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [CNT_WIDTH-1:0] ONE_THR   = CNT_WIDTH'(ONE_THRESHOLD);
   localparam logic [CNT_WIDTH-1:0] GAP_LIMIT = CNT_WIDTH'(GAP_TIMEOUT);
   localparam logic [BCW-1:0]       LAST_BIT  = BCW'(MSG_WIDTH - 1);
   localparam logic [BCW-1:0]       FULL_CNT  = BCW'(MSG_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HIGH  = 2'd1,
      ST_LOW   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   line_s;

   state_e                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   high_q, high_d;
   logic [CNT_WIDTH-1:0]   gap_q, gap_d;
   logic [MSG_WIDTH-1:0]   shift_q, shift_d;
   logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [MSG_WIDTH-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ovr_q, ovr_d;
   logic                   ferr_q, ferr_d;
   logic                   busy_q, busy_d;
   logic                   complete_c;
   logic                   bit_c;

   assign line_s = sync_q[SYNC_STAGES-1];

   // Synchroniser for the asynchronous serial line.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], neo_in};
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         high_q    <= '0;
         gap_q     <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         high_q    <= high_d;
         gap_q     <= gap_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
         ferr_q    <= ferr_d;
         busy_q    <= busy_d;
      end
   end

   // Pulse decoder: measures high and low durations, shifts decoded bits.
   always_comb begin
      state_d    = state_q;
      high_d     = high_q;
      gap_d      = gap_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      ferr_d     = 1'b0;
      complete_c = 1'b0;
      bit_c      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (line_s) begin
               state_d = ST_HIGH;
               high_d  = CNT_WIDTH'(1);
            end
         end

         ST_HIGH: begin
            if (line_s) begin
               if (high_q != CNT_MAX) begin
                  high_d = high_q + CNT_WIDTH'(1);
               end
               // A stuck-high line is a framing fault; wait for it to fall.
               if (high_d == CNT_MAX) begin
                  ferr_d    = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = ST_DRAIN;
               end
            end else begin
               bit_c   = (high_q > ONE_THR);
               shift_d = {shift_q[MSG_WIDTH-2:0], bit_c};
               if (bit_cnt_q == LAST_BIT) begin
                  complete_c = 1'b1;
                  bit_cnt_d  = '0;
                  state_d    = ST_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
                  gap_d     = '0;
                  state_d   = ST_LOW;
               end
            end
         end

         ST_LOW: begin
            if (line_s) begin
               state_d = ST_HIGH;
               high_d  = CNT_WIDTH'(1);
            end else if ((gap_q == GAP_LIMIT) && (bit_cnt_q != '0) && (bit_cnt_q < FULL_CNT)) begin
               ferr_d    = 1'b1;
               bit_cnt_d = '0;
               state_d   = ST_IDLE;
            end else if (gap_q != CNT_MAX) begin
               gap_d = gap_q + CNT_WIDTH'(1);
            end
         end

         ST_DRAIN: begin
            if (!line_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output holding register with valid/ack handshake and overrun detection.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;

      if (complete_c) begin
         if (!valid_q || msg_ack) begin
            data_d  = shift_d;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && msg_ack) begin
         valid_d = 1'b0;
      end

      busy_d = (bit_cnt_d != '0) || (state_d == ST_HIGH);
   end

   assign msg_data    = data_q;
   assign msg_valid   = valid_q;
   assign overrun     = ovr_q;
   assign frame_error = ferr_q;
   assign busy        = busy_q;
   assign bit_count   = bit_cnt_q;

endmodule

// File: tb/tb_pw_msg_receiver.sv
// Self-checking bench for pw_msg_receiver: directed scenarios plus randomized pulse
// timing, checked against a message-level reference model.
module tb_pw_msg_receiver;

   localparam int MW   = 24;
   localparam int CW   = 6;
   localparam int THR  = 26;
   localparam int GAP  = 48;
   localparam int SYNC = 2;
   localparam int HMAX = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset;
   logic          neo_in;
   logic          msg_ack;
   logic [MW-1:0] msg_data;
   logic          msg_valid;
   logic          overrun;
   logic          frame_error;
   logic          busy;
   logic [4:0]    bit_count;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int fe_cnt = 0;
   int fe_cyc = 0;

   // Reference model of the consumer-visible message state.
   logic [MW-1:0] m_data;
   logic          m_valid;
   logic          m_ovr;

   pw_msg_receiver #(
      .MSG_WIDTH(MW), .CNT_WIDTH(CW), .ONE_THRESHOLD(THR),
      .GAP_TIMEOUT(GAP), .SYNC_STAGES(SYNC)
   ) dut (
      .clock(clock), .reset(reset), .neo_in(neo_in),
      .msg_data(msg_data), .msg_valid(msg_valid), .msg_ack(msg_ack),
      .overrun(overrun), .frame_error(frame_error), .busy(busy),
      .bit_count(bit_count)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (frame_error === 1'b1) begin
         fe_cnt <= fe_cnt + 1;
         fe_cyc <= cyc + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_valid"}, 32'(msg_valid), 32'(m_valid));
      chk({tag, "_data"},  32'(msg_data),  32'(m_data));
      chk({tag, "_ovr"},   32'(overrun),   32'(m_ovr));
   endtask

   function automatic int rnd_hi(input logic b);
      return b ? int'($urandom_range(62, THR + 1)) : int'($urandom_range(THR, 1));
   endfunction

   task automatic send_bit(input logic b, input int hi, input int lo);
      neo_in = b | 1'b1;
      tick(hi);
      neo_in = 1'b0;
      tick(lo);
   endtask

   // Last bit: completion lands SYNC+1 edges after the line falls; ack optionally on that edge.
   task automatic finish_word(input logic [MW-1:0] w, input int hi, input logic ack);
      neo_in = 1'b1;
      tick(hi);
      neo_in = 1'b0;
      tick(SYNC);
      chk("pre_done_valid", 32'(msg_valid), 32'(m_valid));
      msg_ack = ack;
      tick(1);
      msg_ack = 1'b0;
      if (!m_valid || ack) begin
         m_data  = w;
         m_valid = 1'b1;
      end else begin
         m_ovr = 1'b1;
      end
      check_model("done");
      chk("done_cnt", 32'(bit_count), 32'd0);
      tick(19);
      chk("done_busy", 32'(busy), 32'd0);
   endtask

   task automatic send_word(input logic [MW-1:0] w, input logic rnd, input logic ack);
      logic b;
      int   hi;
      int   lo;
      for (int i = MW - 1; i >= 1; i--) begin
         b  = w[i];
         hi = rnd ? rnd_hi(b) : (b ? 40 : 12);
         lo = rnd ? int'($urandom_range(40, 3)) : 20;
         send_bit(b, hi, lo);
      end
      chk("mid_cnt", 32'(bit_count), 32'(MW - 1));
      chk("mid_busy", 32'(busy), 32'd1);
      hi = rnd ? rnd_hi(w[0]) : (w[0] ? 40 : 12);
      finish_word(w, hi, ack);
   endtask

   task automatic do_ack();
      msg_ack = 1'b1;
      tick(1);
      msg_ack = 1'b0;
      m_valid = 1'b0;
      check_model("ack");
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      tick(1);
   endtask

   initial begin
      logic [MW-1:0] w;
      int            fe0;
      int            t0;
      int            dt;

      reset   = 1'b1;
      neo_in  = 1'b0;
      msg_ack = 1'b0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      tick(3);
      chk("rst_valid", 32'(msg_valid), 32'd0);
      chk("rst_data",  32'(msg_data),  32'd0);
      chk("rst_ovr",   32'(overrun),   32'd0);
      chk("rst_ferr",  32'(frame_error), 32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_cnt",   32'(bit_count), 32'd0);
      reset = 1'b0;
      tick(1);

      // Fixed-timing message, held until acknowledged.
      send_word(24'hA5C3F0, 1'b0, 1'b0);
      chk("a5_data", 32'(msg_data), 32'h00A5C3F0);
      tick(30);
      chk("a5_hold_valid", 32'(msg_valid), 32'd1);
      chk("a5_hold_data", 32'(msg_data), 32'h00A5C3F0);
      msg_ack = 1'b1;
      tick(1);
      msg_ack = 1'b0;
      m_valid = 1'b0;
      chk("a5_ack_valid", 32'(msg_valid), 32'd0);

      // Threshold boundary: 26-cycle high is 0, 27-cycle high is 1.
      w = {2'b01, 22'($urandom)};
      send_bit(1'b0, THR, 20);
      send_bit(1'b1, THR + 1, 20);
      for (int i = MW - 3; i >= 1; i--) begin
         send_bit(w[i], rnd_hi(w[i]), int'($urandom_range(40, 3)));
      end
      finish_word(w, rnd_hi(w[0]), 1'b0);
      chk("thr_msb", 32'(msg_data[23]), 32'd0);
      chk("thr_msb1", 32'(msg_data[22]), 32'd1);
      do_ack();

      // Gap timeout after a partial 10-bit message.
      for (int i = 0; i < 9; i++) begin
         send_bit(1'b1, rnd_hi(1'b1), 20);
      end
      chk("gap_cnt_pre", 32'(bit_count), 32'd9);
      neo_in = 1'b1;
      tick(rnd_hi(1'b0));
      neo_in = 1'b0;
      fe0 = fe_cnt;
      t0  = cyc;
      tick(60);
      dt = fe_cyc - t0;
      chk("gap_ferr_cnt", 32'(fe_cnt - fe0), 32'd1);
      chk("gap_ferr_time", 32'((dt >= GAP + SYNC) && (dt <= GAP + SYNC + 3)), 32'd1);
      chk("gap_cnt", 32'(bit_count), 32'd0);
      chk("gap_valid", 32'(msg_valid), 32'd0);
      chk("gap_busy", 32'(busy), 32'd0);
      send_word(24'($urandom), 1'b1, 1'b0);
      do_ack();

      // Stuck-high line saturates the high timer.
      fe0 = fe_cnt;
      t0  = cyc;
      neo_in = 1'b1;
      tick(10);
      chk("sat_busy_high", 32'(busy), 32'd1);
      tick(90);
      dt = fe_cyc - t0;
      chk("sat_ferr_cnt", 32'(fe_cnt - fe0), 32'd1);
      chk("sat_ferr_time", 32'((dt >= HMAX + SYNC - 1) && (dt <= HMAX + SYNC + 2)), 32'd1);
      chk("sat_cnt", 32'(bit_count), 32'd0);
      chk("sat_busy", 32'(busy), 32'd0);
      neo_in = 1'b0;
      tick(5);
      chk("sat_idle_busy", 32'(busy), 32'd0);
      send_word(24'($urandom), 1'b1, 1'b0);
      do_ack();

      // Overrun: second message dropped when not acknowledged.
      send_word(24'h000001, 1'b1, 1'b0);
      send_word(24'hFFFFFF, 1'b1, 1'b0);
      chk("ovr_data", 32'(msg_data), 32'h00000001);
      chk("ovr_flag", 32'(overrun), 32'd1);
      tick(10);
      chk("ovr_sticky", 32'(overrun), 32'd1);

      // Ack coinciding with completion loads the new message without overrun.
      do_reset();
      send_word(24'h000001, 1'b1, 1'b0);
      send_word(24'hFFFFFF, 1'b1, 1'b1);
      chk("coin_data", 32'(msg_data), 32'h00FFFFFF);
      chk("coin_valid", 32'(msg_valid), 32'd1);
      chk("coin_ovr", 32'(overrun), 32'd0);
      send_word(24'($urandom), 1'b1, 1'b0);
      chk("coin_ovr2", 32'(overrun), 32'd1);
      chk("coin_keep", 32'(msg_data), 32'h00FFFFFF);

      // Reset mid-message clears everything without a framing error.
      for (int i = 0; i < 12; i++) begin
         send_bit(1'($urandom), rnd_hi(1'($urandom)), 20);
      end
      chk("mid_rst_cnt_pre", 32'(bit_count), 32'd12);
      fe0 = fe_cnt;
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(msg_valid), 32'd0);
      chk("mid_rst_data",  32'(msg_data),  32'd0);
      chk("mid_rst_ovr",   32'(overrun),   32'd0);
      chk("mid_rst_ferr",  32'(frame_error), 32'd0);
      chk("mid_rst_busy",  32'(busy),      32'd0);
      chk("mid_rst_cnt",   32'(bit_count), 32'd0);
      tick(2);
      reset = 1'b0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      tick(1);
      chk("mid_rst_no_ferr", 32'(fe_cnt - fe0), 32'd0);
      send_word(24'($urandom), 1'b1, 1'b0);

      // Randomized traffic with random acknowledge behaviour.
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(1, 0) == 1) begin
            do_ack();
         end
         send_word(24'($urandom), 1'b1, 1'($urandom_range(1, 0)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pw_msg_receiver.md
PW_MSG_RECEIVER -- requirements
Module: pw_msg_receiver

Interface
REQ-001 The block SHALL have parameter MSG_WIDTH, default 24: number of bits per message.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 6: width of the pulse and gap timers.
REQ-003 The block SHALL have parameter ONE_THRESHOLD, default 26: a high pulse longer than this many cycles decodes as 1.
REQ-004 The block SHALL have parameter GAP_TIMEOUT, default 48: the low-gap length, in cycles, that aborts a partial message. It SHALL be less than 2**CNT_WIDTH-1.
REQ-005 The block SHALL have parameter SYNC_STAGES, default 2: the input synchroniser depth, 2 or more.
REQ-006 Port clock, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port neo_in, input, 1 bit: asynchronous serial line, idle low.
REQ-009 Port msg_data, output, MSG_WIDTH bits: the held message; the first bit received is the MSB.
REQ-010 Port msg_valid, output, 1 bit: high while msg_data holds an unacknowledged message.
REQ-011 Port msg_ack, input, 1 bit: consumer acknowledge.
REQ-012 Port overrun, output, 1 bit: sticky flag; a complete message was dropped.
REQ-013 Port frame_error, output, 1 bit: one-cycle pulse; a partial message was discarded.
REQ-014 Port busy, output, 1 bit: high while a message is partially received.
REQ-015 Port bit_count, output, $clog2(MSG_WIDTH+1) bits: number of bits received in the current message.

Function
REQ-016 neo_in SHALL pass through SYNC_STAGES flops, producing line_s; all decoding SHALL use line_s only.
REQ-017 The FSM SHALL have states IDLE, HIGH, LOW and DRAIN.
REQ-018 The high timer SHALL be cleared on entry to HIGH and SHALL increment each cycle in HIGH, saturating at 2**CNT_WIDTH-1.
REQ-019 In IDLE or LOW, line_s=1 SHALL cause entry to HIGH with the high timer loaded to 1.
REQ-020 In HIGH, line_s=0 (falling edge) SHALL decode bit = (high timer > ONE_THRESHOLD).
REQ-021 On that falling edge, the decoded bit SHALL shift into the LSB of the shift register with a left shift, bit_count SHALL increment, and the FSM SHALL go to LOW with the gap timer cleared.
REQ-022 When the falling edge brings bit_count to MSG_WIDTH, the shift result SHALL be marked complete, bit_count SHALL clear, and the FSM SHALL go to IDLE.
REQ-023 A complete message SHALL be written to msg_data, with msg_valid high on the following cycle (latency 1 cycle after the last falling edge).
REQ-024 If the high timer saturates while in HIGH, the FSM SHALL pulse frame_error, clear bit_count, and go to DRAIN.
REQ-025 DRAIN SHALL return to IDLE on the first cycle with line_s=0.
REQ-026 In LOW, the gap timer SHALL increment each cycle.
REQ-027 When the gap timer reaches GAP_TIMEOUT with 0 < bit_count < MSG_WIDTH, the block SHALL pulse frame_error, clear bit_count, and go to IDLE.
REQ-028 Once asserted, msg_valid SHALL stay high, with msg_data stable, until the first cycle msg_ack=1; msg_valid SHALL clear on the next edge.
REQ-029 msg_ack while msg_valid=0 SHALL be ignored.
REQ-030 Reception SHALL continue while msg_valid=1.
REQ-031 If a message completes while msg_valid=1 and msg_ack=0, the new message SHALL be dropped, msg_data SHALL keep the old value, and overrun SHALL set.
REQ-032 If completion and msg_ack=1 coincide, the new message SHALL load into msg_data, msg_valid SHALL stay high, and overrun SHALL NOT set.
REQ-033 overrun SHALL clear only on reset.
REQ-034 busy SHALL equal (bit_count != 0) or (state == HIGH).

Reset
REQ-035 On reset assertion, asynchronously: state=IDLE; synchroniser, shift register, msg_data and timers = 0; bit_count = 0; msg_valid, overrun, frame_error and busy = 0.
REQ-036 Reset asserted mid-message SHALL discard the partial message without pulsing frame_error.
REQ-037 After reset release, the first message SHALL decode correctly when its first rising edge arrives one or more cycles later.

Verification
REQ-038 Defaults; send 0xA5C3F0 as 24 bits, using 40-cycle highs for 1, 12-cycle highs for 0, and 20-cycle lows -> msg_valid=1 and msg_data=0xA5C3F0, held until msg_ack, then msg_valid=0 the next cycle.
REQ-039 Threshold boundary: a 24-bit message whose first bit is a 26-cycle high and second bit a 27-cycle high -> msg_data[23]=0 and msg_data[22]=1.
REQ-040 Send 10 bits, then hold low for 60 cycles -> exactly one frame_error pulse at gap count 48, bit_count=0, msg_valid=0; a following full message decodes correctly.
REQ-041 Send 0x000001 without ack, then 0xFFFFFF -> msg_data=0x000001, overrun=1; with msg_ack asserted on the completion cycle of the second message -> msg_data=0xFFFFFF, msg_valid=1, overrun=0.
REQ-042 Hold neo_in high for 100 cycles -> frame_error pulses once at saturation (63); no bits are counted; the block returns to IDLE when the line falls.
REQ-043 Assert reset after 12 bits -> all outputs 0 immediately, no frame_error; the next full message decodes correctly.
